// File: rtl/pipe_pkg.sv
// Shared pipeline-register widths, occupancy encodings and slot-state type.
package pipe_pkg;

  localparam int unsigned D2E_CTRL_W = 8;
  localparam int unsigned D2E_DATA_W = 101;
  localparam int unsigned E2M_CTRL_W = 8;
  localparam int unsigned E2M_DATA_W = 101;
  localparam int unsigned M2W_CTRL_W = 8;
  localparam int unsigned M2W_DATA_W = 101;

  localparam int unsigned OCC_W = 2;
  localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
  localparam logic [OCC_W-1:0] OCC_FULL  = 2'd2;

  // State encoding doubles as the occupancy count.
  typedef enum logic [OCC_W-1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_ONE   = OCC_ONE,
    ST_FULL  = OCC_FULL
  } slot_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid + ctrl + data, with load and clear; invalid entries hold zero payload.
module pipe_slot #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 101
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              ld,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Next entry value: clear beats load, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = '0;
    end else if (ld) begin
      valid_d = valid_in;
      ctrl_d  = valid_in ? ctrl_in : '0;
      data_d  = valid_in ? data_in : '0;
    end
  end

  // Entry register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register with valid/ready handshake, flush and optional skid entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 101,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  slot_state_t state_d, state_q;
  logic        in_ready_d, in_ready_q;
  logic        accept_c, deliver_c;

  logic              main_ld_c, main_vin_c;
  logic [CTRL_W-1:0] main_ctrl_in_c;
  logic [DATA_W-1:0] main_data_in_c;
  logic              skid_ld_c, skid_vin_c;
  logic [CTRL_W-1:0] skid_ctrl_in_c;
  logic [DATA_W-1:0] skid_data_in_c;

  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign accept_c  = in_valid & in_ready;
  assign deliver_c = out_valid & out_ready;

  // Occupancy FSM and slot load steering; skid entry is always older than the input.
  always_comb begin
    state_d        = state_q;
    main_ld_c      = 1'b0;
    main_vin_c     = 1'b0;
    main_ctrl_in_c = '0;
    main_data_in_c = '0;
    skid_ld_c      = 1'b0;
    skid_vin_c     = 1'b0;
    skid_ctrl_in_c = '0;
    skid_data_in_c = '0;
    case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          main_ld_c      = 1'b1;
          main_vin_c     = 1'b1;
          main_ctrl_in_c = in_ctrl;
          main_data_in_c = in_data;
          state_d        = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept_c && deliver_c) begin
          main_ld_c      = 1'b1;
          main_vin_c     = 1'b1;
          main_ctrl_in_c = in_ctrl;
          main_data_in_c = in_data;
        end else if (accept_c) begin
          skid_ld_c      = 1'b1;
          skid_vin_c     = 1'b1;
          skid_ctrl_in_c = in_ctrl;
          skid_data_in_c = in_data;
          state_d        = ST_FULL;
        end else if (deliver_c) begin
          main_ld_c = 1'b1;
          state_d   = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (deliver_c) begin
          main_ld_c      = 1'b1;
          main_vin_c     = skid_valid;
          main_ctrl_in_c = skid_ctrl;
          main_data_in_c = skid_data;
          skid_ld_c      = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
    in_ready_d = (state_d != ST_FULL);
  end

  // State and registered in_ready; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk      (clk),
    .reset    (reset),
    .clr      (flush),
    .ld       (main_ld_c),
    .valid_in (main_vin_c),
    .ctrl_in  (main_ctrl_in_c),
    .data_in  (main_data_in_c),
    .valid_o  (out_valid),
    .ctrl_o   (out_ctrl),
    .data_o   (out_data)
  );

  // Skid entry and in_ready source depend on the configuration.
  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .clr      (flush),
        .ld       (skid_ld_c),
        .valid_in (skid_vin_c),
        .ctrl_in  (skid_ctrl_in_c),
        .data_in  (skid_data_in_c),
        .valid_o  (skid_valid),
        .ctrl_o   (skid_ctrl),
        .data_o   (skid_data)
      );
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      logic unused_skid;
      assign skid_valid  = 1'b0;
      assign skid_ctrl   = '0;
      assign skid_data   = '0;
      assign unused_skid = ^{skid_ld_c, skid_vin_c, skid_ctrl_in_c, skid_data_in_c, in_ready_q};
      assign in_ready    = ~out_valid | out_ready;
    end
  endgenerate

  assign occupancy = OCC_W'(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid instance and one single-register instance.
module tb_pipe_stage_reg;

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;

  logic          s0_reset, s0_flush, s0_in_valid, s0_out_ready;
  logic          s0_in_ready, s0_out_valid;
  logic [CW-1:0] s0_in_ctrl, s0_out_ctrl;
  logic [DW-1:0] s0_in_data, s0_out_data;
  logic [1:0]    s0_occupancy;

  int tests_run = 0;
  int tests_failed = 0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
    .clk(clk), .reset(s0_reset), .flush(s0_flush), .in_valid(s0_in_valid), .in_ready(s0_in_ready),
    .in_ctrl(s0_in_ctrl), .in_data(s0_in_data), .out_valid(s0_out_valid), .out_ready(s0_out_ready),
    .out_ctrl(s0_out_ctrl), .out_data(s0_out_data), .occupancy(s0_occupancy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] v);
    in_valid = 1'b1;
    in_ctrl  = v;
    in_data  = DW'(v);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_ctrl = 8'hFF; in_data = DW'(8'h55);
    s0_reset = 1'b1; s0_flush = 1'b0; s0_in_valid = 1'b1; s0_out_ready = 1'b0;
    s0_in_ctrl = 8'hFF; s0_in_data = DW'(8'h55);

    // 1: reset for 2 cycles with in_valid held high
    tick(); tick();
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_ctrl", 128'(out_ctrl), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    check("rst_occ", 128'(occupancy), 128'(0));
    check("rst0_out_valid", 128'(s0_out_valid), 128'(0));
    reset = 1'b0; in_valid = 1'b0; s0_reset = 1'b0; s0_in_valid = 1'b0;
    tick();
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_occ_after", 128'(occupancy), 128'(0));

    // 2: streaming with out_ready=1, no gaps
    out_ready = 1'b1;
    offer(8'h10); tick();
    check("stream_v0", 128'(out_valid), 128'(1));
    check("stream_d0", 128'(out_data), 128'h10);
    check("stream_c0", 128'(out_ctrl), 128'h10);
    offer(8'h11); tick();
    check("stream_d1", 128'(out_data), 128'h11);
    check("stream_occ1", 128'(occupancy), 128'(1));
    offer(8'h12); tick();
    check("stream_d2", 128'(out_data), 128'h12);
    check("stream_v2", 128'(out_valid), 128'(1));
    in_valid = 1'b0; tick();
    check("stream_drain_v", 128'(out_valid), 128'(0));
    check("stream_drain_ctrl", 128'(out_ctrl), 128'(0));
    check("stream_drain_data", 128'(out_data), 128'(0));
    check("stream_drain_occ", 128'(occupancy), 128'(0));

    // 3: stall fills main then skid; C held upstream; release drains in order
    out_ready = 1'b0;
    offer(8'h0A); tick();
    check("skid_a_out", 128'(out_data), 128'h0A);
    check("skid_a_occ", 128'(occupancy), 128'(1));
    check("skid_a_rdy", 128'(in_ready), 128'(1));
    offer(8'h0B); tick();
    check("skid_b_out", 128'(out_data), 128'h0A);
    check("skid_b_occ", 128'(occupancy), 128'(2));
    check("skid_b_rdy", 128'(in_ready), 128'(0));
    offer(8'h0C); tick();
    check("skid_c_hold_out", 128'(out_data), 128'h0A);
    check("skid_c_hold_occ", 128'(occupancy), 128'(2));
    out_ready = 1'b1;
    #1;
    check("skid_rdy_no_comb", 128'(in_ready), 128'(0));
    tick();
    check("skid_rel_b", 128'(out_data), 128'h0B);
    check("skid_rel_b_occ", 128'(occupancy), 128'(1));
    check("skid_rel_rdy", 128'(in_ready), 128'(1));
    tick();
    check("skid_rel_c", 128'(out_data), 128'h0C);
    check("skid_rel_c_v", 128'(out_valid), 128'(1));
    in_valid = 1'b0; tick();
    check("skid_rel_empty", 128'(occupancy), 128'(0));

    // 4: flush while FULL with a valid input offered
    out_ready = 1'b0;
    offer(8'h21); tick();
    offer(8'h22); tick();
    check("fl_full_occ", 128'(occupancy), 128'(2));
    flush = 1'b1; offer(8'h0D); tick();
    check("fl_out_valid", 128'(out_valid), 128'(0));
    check("fl_out_ctrl", 128'(out_ctrl), 128'(0));
    check("fl_out_data", 128'(out_data), 128'(0));
    check("fl_occ", 128'(occupancy), 128'(0));
    check("fl_in_ready", 128'(in_ready), 128'(1));
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    check("fl_d_dropped_v", 128'(out_valid), 128'(0));
    check("fl_d_dropped_data", 128'(out_data), 128'(0));

    // 5: SKID=0 combinational in_ready
    s0_out_ready = 1'b0; s0_in_valid = 1'b1; s0_in_ctrl = 8'h05; s0_in_data = DW'(8'h05);
    tick();
    s0_in_valid = 1'b0;
    #1;
    check("s0_hold_data", 128'(s0_out_data), 128'h05);
    check("s0_hold_occ", 128'(s0_occupancy), 128'(1));
    check("s0_stall_rdy", 128'(s0_in_ready), 128'(0));
    s0_out_ready = 1'b1; s0_in_valid = 1'b1; s0_in_ctrl = 8'h06; s0_in_data = DW'(8'h06);
    #1;
    check("s0_rel_rdy", 128'(s0_in_ready), 128'(1));
    tick();
    check("s0_next_data", 128'(s0_out_data), 128'h06);
    check("s0_next_ctrl", 128'(s0_out_ctrl), 128'h06);
    check("s0_next_occ", 128'(s0_occupancy), 128'(1));
    s0_in_valid = 1'b0; tick();
    check("s0_drain_v", 128'(s0_out_valid), 128'(0));
    check("s0_drain_occ", 128'(s0_occupancy), 128'(0));

    // 6: reset together with flush in state ONE
    out_ready = 1'b0;
    offer(8'h31); tick();
    check("rf_one_occ", 128'(occupancy), 128'(1));
    reset = 1'b1; flush = 1'b1; offer(8'h32); tick();
    check("rf_out_valid", 128'(out_valid), 128'(0));
    check("rf_out_ctrl", 128'(out_ctrl), 128'(0));
    check("rf_out_data", 128'(out_data), 128'(0));
    check("rf_occ", 128'(occupancy), 128'(0));
    check("rf_in_ready", 128'(in_ready), 128'(1));
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
